// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR checker: word width,
// feedback taps, checker state encoding and the successor function.
package lfsr_pkg;

  localparam int LFSR_W = 16;

  // Feedback taps 16,15,14,4 (1-based), i.e. bits 15,14,13,3.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hE008;

  // Width needed to hold the popcount of one LFSR word (0..16).
  localparam int INC_W = $clog2(LFSR_W + 1);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } chk_state_t;

  // Next word of the sequence. The all-zero word is a lock-up state of an
  // XOR LFSR, so it is steered back into the sequence at 16'h0001.
  function automatic logic [LFSR_W-1:0] lfsr_succ(input logic [LFSR_W-1:0] cur);
    if (cur == '0) begin
      return LFSR_W'(1);
    end
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational predictor: current reference word -> expected next word.
// Also usable as the next-state logic of a matching pattern generator.
module lfsr_next
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);

  assign nxt = lfsr_succ(cur);

endmodule

// File: rtl/lfsr_checker.sv
// Received-sequence checker for a 16-bit Fibonacci LFSR stream.
// SEARCH -> ACQUIRE (LOCK_CNT consecutive matches) -> LOCKED (flywheel on
// the predicted sequence; LOSS_CNT consecutive misses drop back to SEARCH).
// Build option: define LFSR_CHK_BITERR_EN to accumulate bit errors
// (popcount of the difference) instead of word errors.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [LFSR_W-1:0] i_data,
  input  logic              i_clr,
  output logic              o_locked,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_err_cnt
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);
  localparam int SUM_W   = CNT_W + INC_W;

  chk_state_t          state, state_nx;
  logic [LFSR_W-1:0]   ref_word, ref_nx;
  logic [LFSR_W-1:0]   predicted;
  logic [MATCH_W-1:0]  match_cnt, match_nx;
  logic [MISS_W-1:0]   miss_cnt, miss_nx;
  logic                err_nx;
  logic [INC_W-1:0]    inc;
  logic [SUM_W-1:0]    sum;
  logic [CNT_W-1:0]    cnt_nx;
  logic                hit;

  lfsr_next u_next (
    .cur (ref_word),
    .nxt (predicted)
  );

  assign hit = (i_data == predicted);

  // Lock state machine: next state, reference word and run-length counters.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no
    // path leaves it unassigned, which would infer a latch.
    state_nx = state;
    ref_nx   = ref_word;
    match_nx = match_cnt;
    miss_nx  = miss_cnt;
    err_nx   = 1'b0;
    inc      = '0;
    if (i_valid) begin
      case (state)
        ST_SEARCH: begin
          ref_nx   = i_data;
          match_nx = '0;
          state_nx = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          // While acquiring, the reference follows the received stream.
          ref_nx = i_data;
          if (hit) begin
            match_nx = match_cnt + MATCH_W'(1);
            if (int'(match_cnt) + 1 >= LOCK_CNT) begin
              state_nx = ST_LOCKED;
              miss_nx  = '0;
            end
          end else begin
            match_nx = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: a corrupted word must not disturb the reference.
          ref_nx = predicted;
          if (hit) begin
            miss_nx = '0;
          end else begin
            err_nx  = 1'b1;
`ifdef LFSR_CHK_BITERR_EN
            inc     = INC_W'($countones(i_data ^ predicted));
`else
            inc     = INC_W'(1);
`endif
            miss_nx = miss_cnt + MISS_W'(1);
            if (int'(miss_cnt) + 1 >= LOSS_CNT) begin
              state_nx = ST_SEARCH;
            end
          end
        end
        default: state_nx = ST_SEARCH;
      endcase
    end
  end

  // Saturating error accumulator; a clear overrides a coincident increment.
  always_comb begin
    sum = SUM_W'(o_err_cnt) + SUM_W'(inc);
    if (i_clr) begin
      cnt_nx = '0;
    end else if (sum[SUM_W-1:CNT_W] != '0) begin
      cnt_nx = '1;
    end else begin
      cnt_nx = sum[CNT_W-1:0];
    end
  end

  // State and registered outputs; o_locked tracks the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SEARCH;
      ref_word  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      o_locked  <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state     <= state_nx;
      ref_word  <= ref_nx;
      match_cnt <= match_nx;
      miss_cnt  <= miss_nx;
      o_locked  <= (state_nx == ST_LOCKED);
      o_err     <= err_nx;
      o_err_cnt <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed self-checking bench for lfsr_checker. Two instances: a default
// one, and a narrow-counter one with a large loss threshold for saturation.
// A behavioural model pushes expected outputs to a scoreboard queue as each
// cycle's stimulus is driven; entries are popped and compared after the edge.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_a = 1'b0, clr_a = 1'b0;
  logic [15:0] data_a = '0;
  logic        valid_b = 1'b0, clr_b = 1'b0;
  logic [15:0] data_b = '0;
  logic        locked_a, err_a, locked_b, err_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          idx;
    logic        locked;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Model state, one slot per instance.
  int          m_state [2];   // 0 search, 1 acquire, 2 locked
  logic [15:0] m_ref   [2];
  int          m_match [2];
  int          m_miss  [2];
  logic        m_locked[2];
  logic        m_err   [2];
  int          m_cnt   [2];

  always #5 clk = ~clk;

  lfsr_checker dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (valid_a),
    .i_data    (data_a),
    .i_clr     (clr_a),
    .o_locked  (locked_a),
    .o_err     (err_a),
    .o_err_cnt (cnt_a)
  );

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(100), .CNT_W(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (valid_b),
    .i_data    (data_b),
    .i_clr     (clr_b),
    .o_locked  (locked_b),
    .o_err     (err_b),
    .o_err_cnt (cnt_b)
  );

  // Successor written directly from the bit-level definition.
  function automatic logic [15:0] succ(input logic [15:0] r);
    if (r == 16'h0000) return 16'h0001;
    return {r[14:0], r[15] ^ r[14] ^ r[13] ^ r[3]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_ref[i] = '0; m_match[i] = 0; m_miss[i] = 0;
      m_locked[i] = 1'b0; m_err[i] = 1'b0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic v, input logic [15:0] d, input logic c);
    logic [15:0] pred;
    int add;
    int loss;
    int cmax;
    pred = succ(m_ref[i]);
    add  = 0;
    loss = (i == 0) ? 3 : 100;
    cmax = (i == 0) ? 65535 : 15;
    m_err[i] = 1'b0;
    if (v) begin
      if (m_state[i] == 0) begin
        m_ref[i] = d; m_match[i] = 0; m_state[i] = 1;
      end else if (m_state[i] == 1) begin
        m_ref[i] = d;
        if (d == pred) begin
          m_match[i]++;
          if (m_match[i] == 4) begin m_state[i] = 2; m_miss[i] = 0; end
        end else begin
          m_match[i] = 0;
        end
      end else begin
        m_ref[i] = pred;
        if (d == pred) begin
          m_miss[i] = 0;
        end else begin
          m_err[i] = 1'b1;
`ifdef LFSR_CHK_BITERR_EN
          add = $countones(d ^ pred);
`else
          add = 1;
`endif
          m_miss[i]++;
          if (m_miss[i] == loss) m_state[i] = 0;
        end
      end
    end
    if (c) m_cnt[i] = 0;
    else if (m_cnt[i] + add > cmax) m_cnt[i] = cmax;
    else m_cnt[i] = m_cnt[i] + add;
    m_locked[i] = (m_state[i] == 2);
  endtask

  // One clock: drive instance idx, idle the other, score both.
  task automatic step(input int idx, input logic v, input logic [15:0] d, input logic c);
    exp_t e;
    @(negedge clk);
    valid_a = (idx == 0) ? v : 1'b0;
    data_a  = (idx == 0) ? d : 16'h0000;
    clr_a   = (idx == 0) ? c : 1'b0;
    valid_b = (idx == 1) ? v : 1'b0;
    data_b  = (idx == 1) ? d : 16'h0000;
    clr_b   = (idx == 1) ? c : 1'b0;
    model_step(0, valid_a, data_a, clr_a);
    model_step(1, valid_b, data_b, clr_b);
    for (int i = 0; i < 2; i++) begin
      e.idx = i; e.locked = m_locked[i]; e.err = m_err[i]; e.cnt = 16'(m_cnt[i]);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.idx == 0) begin
        check("a_locked", {15'h0, locked_a}, {15'h0, e.locked});
        check("a_err",    {15'h0, err_a},    {15'h0, e.err});
        check("a_cnt",    cnt_a,             e.cnt);
      end else begin
        check("b_locked", {15'h0, locked_b}, {15'h0, e.locked});
        check("b_err",    {15'h0, err_b},    {15'h0, e.err});
        check("b_cnt",    {12'h0, cnt_b},    e.cnt);
      end
    end
  endtask

  // Assert reset away from any clock edge and require outputs low at once.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_a_locked", {15'h0, locked_a}, 16'h0);
    check("rst_a_err",    {15'h0, err_a},    16'h0);
    check("rst_a_cnt",    cnt_a,             16'h0);
    check("rst_b_locked", {15'h0, locked_b}, 16'h0);
    check("rst_b_err",    {15'h0, err_b},    16'h0);
    check("rst_b_cnt",    {12'h0, cnt_b},    16'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    logic [15:0] w;
    logic [15:0] exp_single;
    model_reset();
    async_reset();

    // Acquire from 0xACE1: five samples lock, no errors.
    w = 16'hACE1;
    for (int k = 0; k < 5; k++) begin
      step(0, 1'b1, w, 1'b0);
      if (k < 4) w = succ(w);
    end
    check("lock_after_5", {15'h0, locked_a}, 16'h1);
    check("cnt_after_lock", cnt_a, 16'h0);

    // Single 2-bit corruption; flywheel keeps lock and the next word matches.
    w = succ(w);
    step(0, 1'b1, w ^ 16'h0003, 1'b0);
`ifdef LFSR_CHK_BITERR_EN
    exp_single = 16'd2;
`else
    exp_single = 16'd1;
`endif
    check("single_err_cnt", cnt_a, exp_single);
    for (int k = 0; k < 3; k++) begin
      w = succ(w);
      step(0, 1'b1, w, 1'b0);
    end
    check("single_still_locked", {15'h0, locked_a}, 16'h1);

    // Clear while idle, then three consecutive misses drop lock.
    step(0, 1'b0, 16'h0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      w = succ(w);
      step(0, 1'b1, w ^ 16'h0100, 1'b0);
    end
    check("loss_unlocked", {15'h0, locked_a}, 16'h0);
    check("loss_cnt", cnt_a, 16'd3);
    for (int k = 0; k < 5; k++) begin
      w = succ(w);
      step(0, 1'b1, w, 1'b0);
    end
    check("relock", {15'h0, locked_a}, 16'h1);

    // Zero word in ACQUIRE: its successor 0x0001 counts as a match.
    async_reset();
    w = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      step(0, 1'b1, w, 1'b0);
      if (k < 4) w = succ(w);
    end
    check("zero_lock", {15'h0, locked_a}, 16'h1);

    // Narrow counter: 20 locked errors saturate at 15; clear beats an error.
    w = 16'h1D2B;
    for (int k = 0; k < 5; k++) begin
      step(1, 1'b1, w, 1'b0);
      if (k < 4) w = succ(w);
    end
    for (int k = 0; k < 20; k++) begin
      w = succ(w);
      step(1, 1'b1, w ^ 16'h0001, 1'b0);
    end
    check("sat_cnt", {12'h0, cnt_b}, 16'd15);
    w = succ(w);
    step(1, 1'b1, w ^ 16'h0001, 1'b1);
    check("clr_wins", {12'h0, cnt_b}, 16'd0);

    // Mid-LOCKED with valid gaps, then async reset; relock needs 5 samples.
    w = 16'h0008;
    step(0, 1'b0, 16'h0000, 1'b0);
    w = succ(w);
    step(0, 1'b1, w, 1'b0);
    step(0, 1'b0, 16'hFFFF, 1'b0);
    step(0, 1'b0, 16'h1234, 1'b0);
    w = succ(w);
    step(0, 1'b1, w ^ 16'h8000, 1'b0);
    async_reset();
    w = 16'hBEEF;
    for (int k = 0; k < 5; k++) begin
      step(0, 1'b1, w, 1'b0);
      if (k == 3) check("relock_not_yet", {15'h0, locked_a}, 16'h0);
      if (k < 4) w = succ(w);
    end
    check("relock_after_rst", {15'h0, locked_a}, 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
